// File: rtl/ram_lane_nxm_pkg.sv
// rtl/ram_lane_nxm_pkg.sv - shared types and defaults for the lane-masked RAM
package ram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  localparam logic WRITE = 1'b1;
  localparam logic READ  = 1'b0;

  localparam int DATA_W_DEF = 8;
  localparam int LANE_W_DEF = 4;
  localparam int DEPTH_DEF  = 2;

endpackage

// File: rtl/ram_lane_nxm_if.sv
// rtl/ram_lane_nxm_if.sv - access/sweep bus of the lane-masked RAM
interface ram_lane_nxm_if
  import ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LANE_W = LANE_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LANES  = DATA_W / LANE_W;

  logic              EN_;
  logic              R_W_;
  logic [ADDR_W-1:0] ADDR_;
  logic [LANES-1:0]  LANE_;
  logic [DATA_W-1:0] DATA_IN;
  logic              SWEEP_;
  logic [DATA_W-1:0] DATA_OUT;
  logic              VALID_;
  logic              BUSY_;

  modport master (
    output EN_, R_W_, ADDR_, LANE_, DATA_IN, SWEEP_,
    input  DATA_OUT, VALID_, BUSY_
  );

  modport slave (
    input  EN_, R_W_, ADDR_, LANE_, DATA_IN, SWEEP_,
    output DATA_OUT, VALID_, BUSY_
  );

endinterface

// File: rtl/ram_lane_nxm_sweep_ctrl.sv
// rtl/ram_lane_nxm_sweep_ctrl.sv - clear-sweep FSM walking every word once
module ram_sweep_ctrl
  import ram_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sweep_i,
  output logic              busy_o,
  output logic              clr_en_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (sweep_i) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o     = (state_q == SWEEP);
  assign clr_en_o   = (state_q == SWEEP);
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/ram_lane_nxm.sv
// rtl/ram_lane_nxm.sv - DEPTH x DATA_W register RAM with lane-masked writes,
// registered read and background clear sweep
module ram_lane_nxm
  import ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LANE_W = LANE_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic          CLK_,
  input  logic          CLR_,
  ram_lane_nxm_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LANES  = DATA_W / LANE_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;

  logic              busy;
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;

  logic              accept;
  logic              in_range;
  logic [DATA_W-1:0] rd_word;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_word;

  ram_sweep_ctrl #(.DEPTH(DEPTH)) u_sweep (
    .clk_i      (CLK_),
    .rst_i      (CLR_),
    .sweep_i    (bus.SWEEP_),
    .busy_o     (busy),
    .clr_en_o   (clr_en),
    .clr_addr_o (clr_addr)
  );

  // A sweep request wins over an access presented in the same cycle.
  assign accept   = bus.EN_ && !busy && !bus.SWEEP_;
  assign in_range = ({1'b0, bus.ADDR_} < DEPTH_L);
  assign rd_word  = in_range ? mem_q[bus.ADDR_] : '0;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = clr_addr;
    wr_word = rd_word;
    dout_d  = dout_q;
    valid_d = 1'b0;
    if (clr_en) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_word = '0;
    end else if (accept && bus.R_W_ == WRITE) begin
      wr_en   = in_range && (|bus.LANE_);
      wr_addr = bus.ADDR_;
      for (int i = 0; i < LANES; i++) begin
        if (bus.LANE_[i]) begin
          wr_word[i*LANE_W +: LANE_W] = bus.DATA_IN[i*LANE_W +: LANE_W];
        end
      end
    end else if (accept && bus.R_W_ == READ) begin
      dout_d  = rd_word;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK_ or posedge CLR_) begin
    if (CLR_) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem_q[w] <= '0;
      end
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_addr] <= wr_word;
      end
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign bus.DATA_OUT = dout_q;
  assign bus.VALID_   = valid_q;
  assign bus.BUSY_    = busy;

endmodule

// File: tb/tb_ram_lane_nxm.sv
// tb/tb_ram_lane_nxm.sv - self-checking bench for ram_lane_nxm (DEPTH 2 and 5)
module tb_ram_lane_nxm;

  typedef struct {
    logic       en;
    logic       rw;
    logic [2:0] addr;
    logic [1:0] lane;
    logic [7:0] din;
    logic       sweep;
  } op_t;

  typedef struct {
    op_t        op;
    logic [7:0] edo;
    logic       ev;
    logic       eb;
  } vec_t;

  logic CLK_ = 1'b0;
  logic clr2 = 1'b1;
  logic clr5 = 1'b1;
  always #5 CLK_ = ~CLK_;

  ram_lane_nxm_if #(.DATA_W(8), .LANE_W(4), .DEPTH(2)) if2 ();
  ram_lane_nxm_if #(.DATA_W(8), .LANE_W(4), .DEPTH(5)) if5 ();

  ram_lane_nxm #(.DATA_W(8), .LANE_W(4), .DEPTH(2)) dut2 (.CLK_(CLK_), .CLR_(clr2), .bus(if2));
  ram_lane_nxm #(.DATA_W(8), .LANE_W(4), .DEPTH(5)) dut5 (.CLK_(CLK_), .CLR_(clr5), .bus(if5));

  int total = 0;
  int bad   = 0;

  // Reference: word arrays plus a "words left to clear" count per instance.
  int         mdep [2] = '{2, 5};
  logic [7:0] mm   [2][8];
  logic [7:0] mdo  [2];
  logic       mv   [2];
  int         mb   [2];

  vec_t tq[$];

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic op_t mk(input int en, input int rw, input int a, input int l,
                             input int dn, input int sw);
    op_t o;
    o.en    = 1'(en);
    o.rw    = 1'(rw);
    o.addr  = 3'(a);
    o.lane  = 2'(l);
    o.din   = 8'(dn);
    o.sweep = 1'(sw);
    return o;
  endfunction

  function automatic op_t idle();
    return mk(0, 0, 0, 0, 0, 0);
  endfunction

  task automatic addv(input op_t o, input int edo, input int ev, input int eb);
    vec_t v;
    v.op  = o;
    v.edo = 8'(edo);
    v.ev  = 1'(ev);
    v.eb  = 1'(eb);
    tq.push_back(v);
  endtask

  task automatic mreset(input int d);
    for (int i = 0; i < 8; i++) mm[d][i] = 8'h00;
    mdo[d] = 8'h00;
    mv[d]  = 1'b0;
    mb[d]  = 0;
  endtask

  task automatic mstep(input int d, input op_t o);
    int a;
    a = (d == 0) ? int'(o.addr[0]) : int'(o.addr);
    if (mb[d] > 0) begin
      mm[d][mdep[d] - mb[d]] = 8'h00;
      mb[d]--;
      mv[d] = 1'b0;
    end else if (o.sweep) begin
      mb[d] = mdep[d];
      mv[d] = 1'b0;
    end else if (o.en && o.rw) begin
      mv[d] = 1'b0;
      if (a < mdep[d]) begin
        if (o.lane[0]) mm[d][a][3:0] = o.din[3:0];
        if (o.lane[1]) mm[d][a][7:4] = o.din[7:4];
      end
    end else if (o.en) begin
      mv[d]  = 1'b1;
      mdo[d] = (a < mdep[d]) ? mm[d][a] : 8'h00;
    end else begin
      mv[d] = 1'b0;
    end
  endtask

  task automatic check_all();
    chk8("dout2", if2.DATA_OUT, mdo[0]);
    chk1("valid2", if2.VALID_, mv[0]);
    chk1("busy2", if2.BUSY_, mb[0] > 0);
    chk8("dout5", if5.DATA_OUT, mdo[1]);
    chk1("valid5", if5.VALID_, mv[1]);
    chk1("busy5", if5.BUSY_, mb[1] > 0);
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 1 after the next.
  task automatic cycle(input op_t a, input op_t b);
    if2.EN_ = a.en; if2.R_W_ = a.rw; if2.ADDR_ = a.addr[0];
    if2.LANE_ = a.lane; if2.DATA_IN = a.din; if2.SWEEP_ = a.sweep;
    if5.EN_ = b.en; if5.R_W_ = b.rw; if5.ADDR_ = b.addr;
    if5.LANE_ = b.lane; if5.DATA_IN = b.din; if5.SWEEP_ = b.sweep;
    @(posedge CLK_);
    mstep(0, a);
    mstep(1, b);
    #1;
    check_all();
  endtask

  task automatic c5(input op_t b);
    cycle(idle(), b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    if2.EN_ = 0; if2.R_W_ = 0; if2.ADDR_ = '0; if2.LANE_ = '0; if2.DATA_IN = '0; if2.SWEEP_ = 0;
    if5.EN_ = 0; if5.R_W_ = 0; if5.ADDR_ = '0; if5.LANE_ = '0; if5.DATA_IN = '0; if5.SWEEP_ = 0;
    mreset(0);
    mreset(1);
    #1;
    check_all();
    #11;
    clr2 = 1'b0;
    clr5 = 1'b0;

    // Directed DEPTH=2 scenario: lane writes, merge, empty mask, sweep priority.
    addv(mk(1, 1, 0, 1, 'hAA, 0), 'h00, 0, 0);
    addv(mk(1, 0, 0, 0, 0, 0),    'h0A, 1, 0);
    addv(idle(),                  'h0A, 0, 0);
    addv(mk(1, 1, 1, 2, 'hCC, 0), 'h0A, 0, 0);
    addv(mk(1, 0, 1, 0, 0, 0),    'hC0, 1, 0);
    addv(mk(1, 0, 0, 0, 0, 0),    'h0A, 1, 0);
    addv(mk(1, 1, 1, 1, 'h33, 0), 'h0A, 0, 0);
    addv(mk(1, 0, 1, 0, 0, 0),    'hC3, 1, 0);
    addv(mk(1, 1, 1, 0, 'hFF, 0), 'hC3, 0, 0);
    addv(mk(1, 0, 1, 0, 0, 0),    'hC3, 1, 0);
    addv(mk(1, 1, 0, 3, 'hFF, 1), 'hC3, 0, 1);
    addv(idle(),                  'hC3, 0, 1);
    addv(idle(),                  'hC3, 0, 0);
    addv(mk(1, 0, 0, 0, 0, 0),    'h00, 1, 0);
    addv(mk(1, 0, 1, 0, 0, 0),    'h00, 1, 0);
    addv(mk(1, 1, 1, 3, 'h5C, 0), 'h00, 0, 0);
    addv(mk(1, 0, 1, 0, 0, 0),    'h5C, 1, 0);
    addv(mk(1, 0, 1, 0, 0, 1),    'h5C, 0, 1);
    addv(mk(1, 0, 1, 0, 0, 0),    'h5C, 0, 1);
    addv(idle(),                  'h5C, 0, 0);
    addv(mk(1, 0, 1, 0, 0, 0),    'h00, 1, 0);
    foreach (tq[i]) begin
      cycle(tq[i].op, idle());
      chk8("tbl_dout", if2.DATA_OUT, tq[i].edo);
      chk1("tbl_valid", if2.VALID_, tq[i].ev);
      chk1("tbl_busy", if2.BUSY_, tq[i].eb);
    end

    // DEPTH=5 out-of-range: writes to 5..7 are discarded, reads return 0 with VALID_.
    c5(mk(1, 1, 2, 3, 'h5A, 0));
    c5(mk(1, 0, 2, 0, 0, 0));
    c5(mk(1, 1, 6, 3, 'hFF, 0));
    c5(mk(1, 1, 7, 3, 'hEE, 0));
    c5(mk(1, 0, 6, 0, 0, 0));
    chk8("oor_dout", if5.DATA_OUT, 8'h00);
    chk1("oor_valid", if5.VALID_, 1'b1);
    for (int a = 0; a < 5; a++) c5(mk(1, 0, a, 0, 0, 0));

    // DEPTH=5 reset two cycles into a sweep.
    c5(mk(1, 1, 1, 3, 'h77, 0));
    c5(mk(1, 1, 4, 3, 'h12, 0));
    c5(mk(1, 0, 4, 0, 0, 0));
    c5(mk(0, 0, 0, 0, 0, 1));
    c5(idle());
    c5(idle());
    chk1("pre_rst_busy", if5.BUSY_, 1'b1);
    #2;
    clr5 = 1'b1;
    mreset(1);
    #1;
    chk1("rst_busy", if5.BUSY_, 1'b0);
    chk8("rst_dout", if5.DATA_OUT, 8'h00);
    chk1("rst_valid", if5.VALID_, 1'b0);
    for (int i = 0; i < 5; i++) chk8("rst_word", dut5.mem_q[i], 8'h00);
    #1;
    clr5 = 1'b0;
    c5(mk(1, 1, 3, 3, 'hE7, 0));
    c5(mk(1, 0, 3, 0, 0, 0));
    c5(mk(1, 0, 4, 0, 0, 0));
    c5(mk(1, 0, 3, 0, 0, 0));

    // Reset while a read result is being presented.
    #2;
    clr5 = 1'b1;
    mreset(1);
    #1;
    chk1("rst_rd_valid", if5.VALID_, 1'b0);
    chk8("rst_rd_dout", if5.DATA_OUT, 8'h00);
    #1;
    clr5 = 1'b0;

    // Randomised traffic on both instances against the reference.
    for (int n = 0; n < 400; n++) begin
      op_t r2, r5;
      r2 = mk(($urandom_range(0, 9) < 7) ? 1 : 0, $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 3), $urandom_range(0, 255), ($urandom_range(0, 24) == 0) ? 1 : 0);
      r5 = mk(($urandom_range(0, 9) < 7) ? 1 : 0, $urandom_range(0, 1), $urandom_range(0, 7),
              $urandom_range(0, 3), $urandom_range(0, 255), ($urandom_range(0, 24) == 0) ? 1 : 0);
      cycle(r2, r5);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
